// File: rtl/seq_mult_param.sv
// Radix-2 shift-add sequential multiplier: one multiplier bit per cycle, WIDTH cycles per
// product, signed or unsigned selected per operation. Result held in a registered output.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int CTRW  = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     mcand, acc, acc_nxt;
  logic [WIDTH-1:0]  mplier;
  logic              sgn;
  logic [CTRW-1:0]   cnt;
  logic              last, accept;

  assign last = (cnt == CTRW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiplicand shifts left and multiplier right each step, so bit i always sits at LSB.
  // The signed MSB carries negative weight, hence the subtract on the final step.
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = (last && sgn) ? acc - mcand : acc + mcand;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      sgn    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      p      <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
        mplier <= b;
        sgn    <= signed_mode;
        acc    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CTRW'(1);
        if (last) begin
          p    <= acc_nxt;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param at WIDTH=8 and WIDTH=16: transaction-level model checked every
// cycle, directed corner cases with literal expectations, then randomized traffic.
module tb_seq_mult_param;
  logic clk = 1'b0;
  logic reset;
  logic st8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic st16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8));

  seq_mult_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .signed_mode(sm16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Full product of two w-bit operands, taken modulo 2^(2w).
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic s);
    longint x, y, msk;
    msk = (longint'(1) << w) - 1;
    x = longint'(a) & msk;
    y = longint'(b) & msk;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Model: an accepted op completes w edges later; nothing else changes p.
  typedef struct {
    int          rem;
    logic        busy, done;
    logic [63:0] p, pend;
  } mdl_t;

  mdl_t m8, m16;

  function automatic mdl_t step(input mdl_t m, input int w, input logic rst, input logic st,
                                input logic sm, input logic [31:0] a, input logic [31:0] b);
    mdl_t n = m;
    if (rst) begin
      n.rem = 0; n.busy = 0; n.done = 0; n.p = '0; n.pend = '0;
      return n;
    end
    n.done = 1'b0;
    if (m.rem > 0) begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.busy = 1'b0;
        n.done = 1'b1;
        n.p    = m.pend;
      end
    end else if (st) begin
      n.rem  = w;
      n.busy = 1'b1;
      n.pend = ref_prod(w, a, b, sm);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m8  <= step(m8, 8, reset, st8, sm8, 32'(a8), 32'(b8));
    m16 <= step(m16, 16, reset, st16, sm16, 32'(a16), 32'(b16));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8",  64'(busy8),  64'(m8.busy));
      chk("done8",  64'(done8),  64'(m8.done));
      chk("p8",     64'(p8),     m8.p);
      chk("busy16", 64'(busy16), 64'(m16.busy));
      chk("done16", 64'(done16), 64'(m16.done));
      chk("p16",    64'(p16),    m16.p);
      if (done8 && busy8)   chk("done_and_busy8", 64'(1), 64'(0));
      if (done16 && busy16) chk("done_and_busy16", 64'(1), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current point until done8 rises; operands are scrambled meanwhile.
  task automatic wait8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    end
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (!done16 && n < 60) begin
      tick();
      n++;
      a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
    end
  endtask

  task automatic run8(input string nm, input logic s, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] expp);
    int n;
    st8 = 1'b1; sm8 = s; a8 = a; b8 = b;
    tick();
    st8 = 1'b0;
    wait8(n);
    chk({nm, "_lat"}, 64'(n), 64'(8));
    chk(nm, 64'(p8), 64'(expp));
    tick();
  endtask

  task automatic run16(input string nm, input logic s, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] expp);
    int n;
    st16 = 1'b1; sm16 = s; a16 = a; b16 = b;
    tick();
    st16 = 1'b0;
    wait16(n);
    chk({nm, "_lat"}, 64'(n), 64'(16));
    chk(nm, 64'(p16), 64'(expp));
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    st8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    st16 = 0; sm16 = 0; a16 = 0; b16 = 0;

    chk("ref_7xFD_s",   ref_prod(8, 32'h07, 32'hFD, 1'b1), 64'hFFEB);
    chk("ref_80x80_s",  ref_prod(8, 32'h80, 32'h80, 1'b1), 64'h4000);
    chk("ref_FFxFF_u",  ref_prod(8, 32'hFF, 32'hFF, 1'b0), 64'hFE01);
    chk("ref_FFFF_u16", ref_prod(16, 32'hFFFF, 32'hFFFF, 1'b0), 64'hFFFE0001);

    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_p8", 64'(p8), 64'(0));
    chk("reset_busy8", 64'(busy8), 64'(0));
    tick();

    // Signed corner, with busy sampled every cycle of the run.
    st8 = 1; sm8 = 1; a8 = 8'h80; b8 = 8'h80;
    tick();
    st8 = 0;
    for (int i = 0; i < 7; i++) begin
      chk("corner_busy", 64'(busy8), 64'(1));
      tick();
    end
    chk("corner_busy_last", 64'(busy8), 64'(1));
    tick();
    chk("corner_done", 64'(done8), 64'(1));
    chk("corner_p", 64'(p8), 64'h4000);
    tick();

    run8("s_7xFD", 1'b1, 8'h07, 8'hFD, 16'hFFEB);
    run8("s_FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001);
    run8("u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("zero", 1'b0, 8'h00, 8'h00, 16'h0000);

    // start while busy is ignored.
    st8 = 1; sm8 = 1; a8 = 8'h80; b8 = 8'h80;
    tick();
    st8 = 0;
    tick(); tick();
    st8 = 1; sm8 = 0; a8 = 8'h11; b8 = 8'h22;
    tick();
    st8 = 0;
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    chk("ignore_lat", 64'(n), 64'(5));
    chk("ignore_p", 64'(p8), 64'h4000);
    tick();

    // start held high through done: next completion 9 cycles later.
    st8 = 1; sm8 = 0; a8 = 8'h03; b8 = 8'h05;
    tick();
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
    chk("b2b_first_p", 64'(p8), 64'h000F);
    a8 = 8'h10; b8 = 8'h10;
    n = 0;
    tick(); n++;
    while (!done8 && n < 40) begin tick(); n++; end
    st8 = 0;
    chk("b2b_gap", 64'(n), 64'(9));
    chk("b2b_second_p", 64'(p8), 64'h0100);
    tick(); tick();

    // Reset at iteration 4 aborts without a done pulse.
    st8 = 1; sm8 = 0; a8 = 8'h55; b8 = 8'h66;
    tick();
    st8 = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("rst_busy", 64'(busy8), 64'(0));
    chk("rst_done", 64'(done8), 64'(0));
    chk("rst_p", 64'(p8), 64'(0));
    repeat (10) begin
      if (done8) chk("rst_no_done", 64'(1), 64'(0));
      tick();
    end
    run8("after_rst", 1'b0, 8'h55, 8'h66, 16'h21DE);

    run16("s16_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16("u16_FFFF", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

    // Random traffic on both widths; the per-cycle compare does the checking.
    for (int c = 0; c < 40000; c++) begin
      reset = ($urandom_range(0, 999) == 0);
      st8 = ($urandom_range(0, 2) == 0);
      sm8 = 1'($urandom);
      a8 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      b8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      st16 = ($urandom_range(0, 2) == 0);
      sm16 = 1'($urandom);
      a16 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      b16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    reset = 0; st8 = 0; st16 = 0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised radix-2 shift-add sequential multiplier with a start/done handshake and a per-operation signed/unsigned mode.
- Each accepted operation computes the full 2*WIDTH-bit product in exactly WIDTH iteration cycles.
- The result is held stable on a registered output until the next result replaces it.
- Used by the datapath for MUL-class operations where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits (legal: 2..32)
CTRW, $clog2(WIDTH)+1, iteration counter width; derived, do not override

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new multiply; sampled only when busy=0
signed_mode  input  1  1 = two's complement operands, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: p holds a new result
p  output  2*WIDTH  product; registered, held until the next completion

Behaviour:
- Reset:
  - Synchronous: takes effect on a clk edge where reset=1 and overrides all other inputs.
  - busy=0, done=0, p=0, counter=0, accumulator=0, state=IDLE.
  - Reset mid-operation aborts the operation; no done pulse; p=0.
- States: IDLE, RUN.
- IDLE:
  - On an edge with start=1, the block latches a, b and signed_mode.
  - Multiplicand is extended to 2*WIDTH bits: sign-extended if signed_mode=1, else zero-extended.
  - Accumulator=0, counter=0, busy=1, state goes to RUN.
  - Otherwise the block holds.
- RUN, each edge, with i = counter:
  - If multiplier bit i = 1: accumulator += (ext multiplicand << i).
  - Exception: when i = WIDTH-1 and signed_mode=1, the block subtracts instead (the MSB carries weight -2^(WIDTH-1)).
  - counter += 1.
  - All arithmetic is modulo 2^(2*WIDTH).
- Completion, on the RUN edge with i = WIDTH-1:
  - p <= final accumulator value, including that edge's add/sub.
  - done <= 1, busy <= 0, state goes to IDLE.
- Latency: start sampled at edge E0; done=1 and p valid after edge E0+WIDTH. done falls after E0+WIDTH+1 unless another completion occurs.
- start while busy=1 is ignored: operands are not re-latched and no queueing occurs.
- start high in the cycle where done=1 (state IDLE) is accepted. done clears on that edge. Back-to-back throughput is WIDTH+1 cycles per result.
- a, b and signed_mode may change freely after the accepting edge; the block uses only the latched copies.
- p never shows partial sums. It changes only on a completion edge or on reset.
- Zero operands take the full WIDTH cycles; there is no early termination.
- done is never high while busy is high.

Test Plan:
- Signed corner: WIDTH=8, signed_mode=1, a=0x80, b=0x80, pulse start -> done exactly 8 cycles after the start edge, p=0x4000; busy high for those 8 cycles.
- Mixed sign and unsigned: WIDTH=8.
  - signed a=7, b=0xFD -> p=0xFFEB (-21).
  - signed a=0xFF, b=0xFF -> p=0x0001.
  - unsigned a=0xFF, b=0xFF -> p=0xFE01.
- Handshake:
  - start re-asserted while busy with different operands -> ignored; first result (0x4000) is returned intact.
  - start held high through done -> second op accepted on the done cycle; next done 9 cycles after the first.
- Input stability: operands and signed_mode toggle randomly after the accepting edge -> p matches the originally latched operands. p stays at the previous result throughout RUN.
- Reset mid-op: reset=1 for one cycle at iteration 4 -> busy=0, done=0, p=0 next cycle, no done pulse. A new start then completes normally.
- Width generality: WIDTH=16, signed 0x8000*0x8000 -> p=0x40000000 after 16 cycles. WIDTH=16 unsigned 0xFFFF*0xFFFF -> 0xFFFE0001. 10k random signed/unsigned vectors match a reference model.
